// File: rtl/bp_vcache_buffer.sv
// bp_vcache_buffer: fully-associative victim/writeback buffer between the UCE
// memory port and memory. It absorbs block writebacks and acks them locally,
// serves read hits from its own storage, drains entries to memory in FIFO order
// and forwards read misses to memory.
//
// Ports:
//   clk_i, reset_n_i                  clock, asynchronous active-low reset
//   cmd_*                             UCE command (valid/ready handshake)
//   resp_*                            UCE response (valid/yumi handshake)
//   mem_cmd_*                         memory command (drain writes, forwarded reads)
//   mem_resp_*                        memory response (read data, drain write acks)
//   hit_count_o, miss_count_o,        saturating statistics counters, present only
//   drain_count_o                     when BP_VCACHE_BUFFER_STATS_EN is defined
module bp_vcache_buffer #(
    parameter int unsigned paddr_width_p = 40,
    parameter int unsigned block_width_p = 512,
    parameter int unsigned entries_p     = 4,
    parameter int unsigned high_water_p  = 3,
    parameter int unsigned idle_cycles_p = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     cmd_v_i,
    input  logic                     cmd_wr_i,
    input  logic [paddr_width_p-1:0] cmd_addr_i,
    input  logic [block_width_p-1:0] cmd_data_i,
    output logic                     cmd_ready_o,
    output logic                     resp_v_o,
    output logic                     resp_wr_o,
    output logic [paddr_width_p-1:0] resp_addr_o,
    output logic [block_width_p-1:0] resp_data_o,
    input  logic                     resp_yumi_i,
    output logic                     mem_cmd_v_o,
    output logic                     mem_cmd_wr_o,
    output logic [paddr_width_p-1:0] mem_cmd_addr_o,
    output logic [block_width_p-1:0] mem_cmd_data_o,
    input  logic                     mem_cmd_ready_i,
    input  logic                     mem_resp_v_i,
    input  logic                     mem_resp_wr_i,
    input  logic [paddr_width_p-1:0] mem_resp_addr_i,
    input  logic [block_width_p-1:0] mem_resp_data_i,
    output logic                     mem_resp_yumi_o
`ifdef BP_VCACHE_BUFFER_STATS_EN
   ,output logic [31:0]              hit_count_o,
    output logic [31:0]              miss_count_o,
    output logic [31:0]              drain_count_o
`endif
);

    localparam int unsigned offset_width_lp = $clog2(block_width_p / 8);
    localparam int unsigned tag_width_lp    = paddr_width_p - offset_width_lp;
    localparam int unsigned ptr_width_lp    = $clog2(entries_p);
    localparam int unsigned occ_width_lp    = $clog2(entries_p + 1);
    localparam int unsigned idle_width_lp   = $clog2(idle_cycles_p + 1);

    typedef enum logic {IDLE, DRAIN} state_e;

    state_e                    state_r, state_n;
    logic [entries_p-1:0]      valid_r;
    logic [tag_width_lp-1:0]   tag_r  [entries_p];
    logic [block_width_p-1:0]  data_r [entries_p];
    logic [ptr_width_lp-1:0]   head_r, tail_r;
    logic [occ_width_lp-1:0]   occupancy_r;
    logic [idle_width_lp-1:0]  idle_cnt_r;

    logic                      resp_full_r, resp_wr_r;
    logic [paddr_width_p-1:0]  resp_addr_r;
    logic [block_width_p-1:0]  resp_data_r;

    logic [tag_width_lp-1:0]   cmd_tag;
    logic                      hit_any;
    logic [ptr_width_lp-1:0]   hit_idx;
    logic                      drain_hit, full, resp_blocked;
    logic                      is_wr, is_rd_hit, rd_miss, fwd_v;
    logic                      accept_wr, alloc, coalesce, accept_rd_hit, accept_rd_miss;
    logic                      local_push, drain_fire;

    assign cmd_tag = cmd_addr_i[paddr_width_p-1:offset_width_lp];

    // CAM lookup against all valid entries; entries never hold duplicate tags
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < entries_p; i++) begin
            if (valid_r[i] && (tag_r[i] == cmd_tag)) begin
                hit_any = 1'b1;
                hit_idx = ptr_width_lp'(i);
            end
        end
    end

    // Command classification and acceptance
    assign drain_hit      = (state_r == DRAIN) && hit_any && (hit_idx == head_r);
    assign full           = (occupancy_r == occ_width_lp'(entries_p));
    assign resp_blocked   = resp_full_r && !resp_yumi_i;
    assign is_wr          = cmd_v_i && cmd_wr_i;
    assign is_rd_hit      = cmd_v_i && !cmd_wr_i && hit_any;
    assign rd_miss        = cmd_v_i && !cmd_wr_i && !hit_any;
    assign fwd_v          = rd_miss && (state_r == IDLE) && !resp_blocked;
    assign accept_wr      = is_wr && !resp_blocked && !drain_hit && (hit_any || !full);
    assign alloc          = accept_wr && !hit_any;
    assign coalesce       = accept_wr && hit_any;
    assign accept_rd_hit  = is_rd_hit && !resp_blocked;
    assign accept_rd_miss = fwd_v && mem_cmd_ready_i;
    assign local_push     = accept_wr || accept_rd_hit;
    assign drain_fire     = (state_r == DRAIN) && mem_cmd_ready_i;

    // Drain FSM next state; a presented read miss keeps the memory port for itself
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (!rd_miss &&
                    ((occupancy_r >= occ_width_lp'(high_water_p)) ||
                     ((occupancy_r != '0) && (idle_cnt_r == idle_width_lp'(idle_cycles_p)))))
                    state_n = DRAIN;
            end
            DRAIN: begin
                if (mem_cmd_ready_i)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Output muxing; everything is forced low while reset is asserted
    always_comb begin
        cmd_ready_o     = 1'b0;
        resp_v_o        = 1'b0;
        resp_wr_o       = 1'b0;
        resp_addr_o     = '0;
        resp_data_o     = '0;
        mem_cmd_v_o     = 1'b0;
        mem_cmd_wr_o    = 1'b0;
        mem_cmd_addr_o  = '0;
        mem_cmd_data_o  = '0;
        mem_resp_yumi_o = 1'b0;
        if (reset_n_i) begin
            cmd_ready_o = accept_wr || accept_rd_hit || accept_rd_miss;
            if (state_r == DRAIN) begin
                mem_cmd_v_o    = 1'b1;
                mem_cmd_wr_o   = 1'b1;
                mem_cmd_addr_o = {tag_r[head_r], offset_width_lp'(0)};
                mem_cmd_data_o = data_r[head_r];
            end else if (fwd_v) begin
                mem_cmd_v_o    = 1'b1;
                mem_cmd_addr_o = cmd_addr_i;
            end
            // Drain write acks are swallowed here and never reach the UCE
            if (mem_resp_v_i && mem_resp_wr_i)
                mem_resp_yumi_o = 1'b1;
            if (resp_full_r) begin
                resp_v_o    = 1'b1;
                resp_wr_o   = resp_wr_r;
                resp_addr_o = resp_addr_r;
                resp_data_o = resp_data_r;
            end else if (mem_resp_v_i && !mem_resp_wr_i) begin
                resp_v_o        = 1'b1;
                resp_addr_o     = mem_resp_addr_i;
                resp_data_o     = mem_resp_data_i;
                mem_resp_yumi_o = resp_yumi_i;
            end
        end
    end

    // State, pointers, occupancy, idle counter and local response register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r     <= IDLE;
            valid_r     <= '0;
            head_r      <= '0;
            tail_r      <= '0;
            occupancy_r <= '0;
            idle_cnt_r  <= '0;
            resp_full_r <= 1'b0;
            resp_wr_r   <= 1'b0;
            resp_addr_r <= '0;
            resp_data_r <= '0;
        end else begin
            state_r <= state_n;
            if (drain_fire) begin
                valid_r[head_r] <= 1'b0;
                head_r <= (head_r == ptr_width_lp'(entries_p - 1)) ? '0 : head_r + 1'b1;
            end
            if (alloc) begin
                valid_r[tail_r] <= 1'b1;
                tail_r <= (tail_r == ptr_width_lp'(entries_p - 1)) ? '0 : tail_r + 1'b1;
            end
            if (alloc && !drain_fire)
                occupancy_r <= occupancy_r + 1'b1;
            else if (!alloc && drain_fire)
                occupancy_r <= occupancy_r - 1'b1;
            if (cmd_v_i)
                idle_cnt_r <= '0;
            else if (idle_cnt_r != idle_width_lp'(idle_cycles_p))
                idle_cnt_r <= idle_cnt_r + 1'b1;
            if (local_push) begin
                resp_full_r <= 1'b1;
                resp_wr_r   <= cmd_wr_i;
                resp_addr_r <= cmd_addr_i;
                resp_data_r <= cmd_wr_i ? '0 : data_r[hit_idx];
            end else if (resp_full_r && resp_yumi_i) begin
                resp_full_r <= 1'b0;
            end
        end
    end

    // Entry storage; no reset needed since valid bits qualify every use
    always_ff @(posedge clk_i) begin
        if (alloc) begin
            tag_r[tail_r]  <= cmd_tag;
            data_r[tail_r] <= cmd_data_i;
        end else if (coalesce) begin
            data_r[hit_idx] <= cmd_data_i;
        end
    end

`ifdef BP_VCACHE_BUFFER_STATS_EN
    // Saturating event counters
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hit_count_o   <= '0;
            miss_count_o  <= '0;
            drain_count_o <= '0;
        end else begin
            if (accept_rd_hit && (hit_count_o != '1))
                hit_count_o <= hit_count_o + 1'b1;
            if (accept_rd_miss && (miss_count_o != '1))
                miss_count_o <= miss_count_o + 1'b1;
            if (drain_fire && (drain_count_o != '1))
                drain_count_o <= drain_count_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_bp_vcache_buffer.sv
// Directed bench for bp_vcache_buffer with default parameters.
module tb_bp_vcache_buffer;

    logic         clk_i = 1'b0;
    logic         reset_n_i;
    logic         cmd_v_i, cmd_wr_i;
    logic [39:0]  cmd_addr_i;
    logic [511:0] cmd_data_i;
    logic         cmd_ready_o;
    logic         resp_v_o, resp_wr_o;
    logic [39:0]  resp_addr_o;
    logic [511:0] resp_data_o;
    logic         resp_yumi_i;
    logic         mem_cmd_v_o, mem_cmd_wr_o;
    logic [39:0]  mem_cmd_addr_o;
    logic [511:0] mem_cmd_data_o;
    logic         mem_cmd_ready_i;
    logic         mem_resp_v_i, mem_resp_wr_i;
    logic [39:0]  mem_resp_addr_i;
    logic [511:0] mem_resp_data_i;
    logic         mem_resp_yumi_o;
`ifdef BP_VCACHE_BUFFER_STATS_EN
    logic [31:0]  hit_count_o, miss_count_o, drain_count_o;
`endif

    int errors = 0;
    int checks = 0;

    bp_vcache_buffer dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .cmd_v_i(cmd_v_i), .cmd_wr_i(cmd_wr_i), .cmd_addr_i(cmd_addr_i),
        .cmd_data_i(cmd_data_i), .cmd_ready_o(cmd_ready_o),
        .resp_v_o(resp_v_o), .resp_wr_o(resp_wr_o), .resp_addr_o(resp_addr_o),
        .resp_data_o(resp_data_o), .resp_yumi_i(resp_yumi_i),
        .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_wr_o(mem_cmd_wr_o),
        .mem_cmd_addr_o(mem_cmd_addr_o), .mem_cmd_data_o(mem_cmd_data_o),
        .mem_cmd_ready_i(mem_cmd_ready_i),
        .mem_resp_v_i(mem_resp_v_i), .mem_resp_wr_i(mem_resp_wr_i),
        .mem_resp_addr_i(mem_resp_addr_i), .mem_resp_data_i(mem_resp_data_i),
        .mem_resp_yumi_o(mem_resp_yumi_o)
`ifdef BP_VCACHE_BUFFER_STATS_EN
       ,.hit_count_o(hit_count_o), .miss_count_o(miss_count_o),
        .drain_count_o(drain_count_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        cv, cw;
        logic [39:0] addr;
        logic [31:0] data;
        logic        mrdy, yumi, mrv, mrw;
        logic [31:0] mrd;
        logic        e_rdy, e_rv, e_rw;
        logic [31:0] e_rd;
        logic        e_mv, e_mw;
        logic [39:0] e_ma;
        logic [31:0] e_md;
        logic        e_my;
        logic [2:0]  e_occ;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_cmd(input logic v, input logic w, input logic [39:0] a, input logic [31:0] d);
        cmd_v_i    = v;
        cmd_wr_i   = w;
        cmd_addr_i = a;
        cmd_data_i = 512'(d);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ctrl"}, 512'({cmd_ready_o, resp_v_o, resp_wr_o, mem_cmd_v_o,
                                 mem_cmd_wr_o, mem_resp_yumi_o}), 512'(0));
        chk({nm, "_addrs"}, 512'({resp_addr_o, mem_cmd_addr_o}), 512'(0));
        chk({nm, "_resp_data"}, resp_data_o, 512'(0));
        chk({nm, "_mem_data"}, mem_cmd_data_o, 512'(0));
        chk({nm, "_occ"}, 512'(dut.occupancy_r), 512'(0));
    endtask

    // Reset with busy inputs so that combinational paths must also be held low
    task automatic do_reset(input string nm);
        reset_n_i       = 1'b0;
        set_cmd(1'b1, 1'b0, 40'h3000, 32'h0);
        resp_yumi_i     = 1'b1;
        mem_cmd_ready_i = 1'b1;
        mem_resp_v_i    = 1'b1;
        mem_resp_wr_i   = 1'b0;
        mem_resp_addr_i = 40'h3000;
        mem_resp_data_i = 512'(32'h5A5A);
        repeat (2) @(posedge clk_i);
        #1;
        chk_all_zero(nm);
        set_cmd(1'b0, 1'b0, 40'h0, 32'h0);
        mem_cmd_ready_i = 1'b0;
        mem_resp_v_i    = 1'b0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    // Waits a bounded number of cycles for a memory command; leaves time at that negedge
    task automatic wait_mem_v(input int max, input string nm);
        logic found;
        found = 1'b0;
        for (int k = 0; k < max; k++) begin
            @(negedge clk_i);
            if (mem_cmd_v_o) begin
                found = 1'b1;
                break;
            end
            next_cycle();
        end
        chk(nm, 512'(found), 512'(1));
    endtask

    initial begin
        //          cv   cw   addr      data    mrdy yumi mrv  mrw  mrd       e_rdy e_rv e_rw e_rd      e_mv e_mw e_ma      e_md    e_my e_occ
        vecs[0]  = '{1'b1,1'b1,40'h1000,32'hD0, 1'b0,1'b1,1'b0,1'b0,32'h0,   1'b1,1'b0,1'b0,32'h0,   1'b0,1'b0,40'h0,   32'h0,  1'b0,3'd0};
        vecs[1]  = '{1'b1,1'b0,40'h1000,32'h0,  1'b0,1'b1,1'b0,1'b0,32'h0,   1'b1,1'b1,1'b1,32'h0,   1'b0,1'b0,40'h0,   32'h0,  1'b0,3'd1};
        vecs[2]  = '{1'b1,1'b1,40'h1000,32'hD1, 1'b0,1'b1,1'b0,1'b0,32'h0,   1'b1,1'b1,1'b0,32'hD0,  1'b0,1'b0,40'h0,   32'h0,  1'b0,3'd1};
        vecs[3]  = '{1'b1,1'b0,40'h1000,32'h0,  1'b0,1'b1,1'b0,1'b0,32'h0,   1'b1,1'b1,1'b1,32'h0,   1'b0,1'b0,40'h0,   32'h0,  1'b0,3'd1};
        vecs[4]  = '{1'b0,1'b0,40'h0,   32'h0,  1'b0,1'b1,1'b0,1'b0,32'h0,   1'b0,1'b1,1'b0,32'hD1,  1'b0,1'b0,40'h0,   32'h0,  1'b0,3'd1};
        vecs[5]  = '{1'b1,1'b0,40'h2000,32'h0,  1'b1,1'b1,1'b0,1'b0,32'h0,   1'b1,1'b0,1'b0,32'h0,   1'b1,1'b0,40'h2000,32'h0,  1'b0,3'd1};
        vecs[6]  = '{1'b1,1'b0,40'h2000,32'h0,  1'b0,1'b1,1'b0,1'b0,32'h0,   1'b0,1'b0,1'b0,32'h0,   1'b1,1'b0,40'h2000,32'h0,  1'b0,3'd1};
        vecs[7]  = '{1'b0,1'b0,40'h0,   32'h0,  1'b0,1'b1,1'b0,1'b0,32'h0,   1'b0,1'b0,1'b0,32'h0,   1'b0,1'b0,40'h0,   32'h0,  1'b0,3'd1};
        vecs[8]  = '{1'b0,1'b0,40'h0,   32'h0,  1'b0,1'b1,1'b1,1'b0,32'hAA,  1'b0,1'b1,1'b0,32'hAA,  1'b0,1'b0,40'h0,   32'h0,  1'b1,3'd1};
        vecs[9]  = '{1'b0,1'b0,40'h0,   32'h0,  1'b0,1'b1,1'b1,1'b1,32'h0,   1'b0,1'b0,1'b0,32'h0,   1'b0,1'b0,40'h0,   32'h0,  1'b1,3'd1};
        vecs[10] = '{1'b1,1'b1,40'h1040,32'hD5, 1'b0,1'b1,1'b1,1'b0,32'hBB,  1'b1,1'b1,1'b0,32'hBB,  1'b0,1'b0,40'h0,   32'h0,  1'b1,3'd1};
        vecs[11] = '{1'b0,1'b0,40'h0,   32'h0,  1'b0,1'b1,1'b1,1'b0,32'hCC,  1'b0,1'b1,1'b1,32'h0,   1'b0,1'b0,40'h0,   32'h0,  1'b0,3'd2};
        vecs[12] = '{1'b0,1'b0,40'h0,   32'h0,  1'b0,1'b1,1'b1,1'b0,32'hCC,  1'b0,1'b1,1'b0,32'hCC,  1'b0,1'b0,40'h0,   32'h0,  1'b1,3'd2};
        vecs[13] = '{1'b1,1'b1,40'h1080,32'hD6, 1'b0,1'b0,1'b0,1'b0,32'h0,   1'b1,1'b0,1'b0,32'h0,   1'b0,1'b0,40'h0,   32'h0,  1'b0,3'd2};
        vecs[14] = '{1'b1,1'b1,40'h10C0,32'hD7, 1'b0,1'b0,1'b0,1'b0,32'h0,   1'b0,1'b1,1'b1,32'h0,   1'b0,1'b0,40'h0,   32'h0,  1'b0,3'd3};
        vecs[15] = '{1'b0,1'b0,40'h0,   32'h0,  1'b0,1'b1,1'b0,1'b0,32'h0,   1'b0,1'b1,1'b1,32'h0,   1'b1,1'b1,40'h1000,32'hD1, 1'b0,3'd3};
        vecs[16] = '{1'b0,1'b0,40'h0,   32'h0,  1'b1,1'b1,1'b0,1'b0,32'h0,   1'b0,1'b0,1'b0,32'h0,   1'b1,1'b1,40'h1000,32'hD1, 1'b0,3'd3};
        vecs[17] = '{1'b0,1'b0,40'h0,   32'h0,  1'b0,1'b1,1'b0,1'b0,32'h0,   1'b0,1'b0,1'b0,32'h0,   1'b0,1'b0,40'h0,   32'h0,  1'b0,3'd2};

        do_reset("reset0");

        // Table: write ack, read hit, coalescing, read miss forwarding, resp mux, drain
        for (int i = 0; i < 18; i++) begin
            next_cycle();
            set_cmd(vecs[i].cv, vecs[i].cw, vecs[i].addr, vecs[i].data);
            mem_cmd_ready_i = vecs[i].mrdy;
            resp_yumi_i     = vecs[i].yumi;
            mem_resp_v_i    = vecs[i].mrv;
            mem_resp_wr_i   = vecs[i].mrw;
            mem_resp_addr_i = 40'h2000;
            mem_resp_data_i = 512'(vecs[i].mrd);
            @(negedge clk_i);
            chk($sformatf("v%0d_cmd_ready", i), 512'(cmd_ready_o), 512'(vecs[i].e_rdy));
            chk($sformatf("v%0d_resp_v", i), 512'(resp_v_o), 512'(vecs[i].e_rv));
            if (vecs[i].e_rv) begin
                chk($sformatf("v%0d_resp_wr", i), 512'(resp_wr_o), 512'(vecs[i].e_rw));
                chk($sformatf("v%0d_resp_data", i), resp_data_o, 512'(vecs[i].e_rd));
            end
            chk($sformatf("v%0d_mem_cmd_v", i), 512'(mem_cmd_v_o), 512'(vecs[i].e_mv));
            if (vecs[i].e_mv) begin
                chk($sformatf("v%0d_mem_cmd_wr", i), 512'(mem_cmd_wr_o), 512'(vecs[i].e_mw));
                chk($sformatf("v%0d_mem_cmd_addr", i), 512'(mem_cmd_addr_o), 512'(vecs[i].e_ma));
                if (vecs[i].e_mw)
                    chk($sformatf("v%0d_mem_cmd_data", i), mem_cmd_data_o, 512'(vecs[i].e_md));
            end
            chk($sformatf("v%0d_mem_resp_yumi", i), 512'(mem_resp_yumi_o), 512'(vecs[i].e_my));
            chk($sformatf("v%0d_occupancy", i), 512'(dut.occupancy_r), 512'(vecs[i].e_occ));
        end

        // High-water drain, held command, drain-entry interactions, idle drain
        do_reset("reset1");
        resp_yumi_i = 1'b1;
        set_cmd(1'b1, 1'b1, 40'h0, 32'h11);
        next_cycle();
        set_cmd(1'b1, 1'b1, 40'h40, 32'h22);
        next_cycle();
        set_cmd(1'b1, 1'b1, 40'h80, 32'h33);
        @(negedge clk_i);
        chk("hw_third_write_ready", 512'(cmd_ready_o), 512'(1));
        chk("hw_occ_before_third", 512'(dut.occupancy_r), 512'(2));
        next_cycle();
        set_cmd(1'b0, 1'b0, 40'h0, 32'h0);
        wait_mem_v(6, "hw_drain_start");
        chk("hw_drain_wr", 512'(mem_cmd_wr_o), 512'(1));
        chk("hw_drain_addr", 512'(mem_cmd_addr_o), 512'(40'h0));
        chk("hw_drain_data", mem_cmd_data_o, 512'(32'h11));
        next_cycle();
        set_cmd(1'b1, 1'b1, 40'h0, 32'h99);
        @(negedge clk_i);
        chk("drain_entry_write_stall", 512'(cmd_ready_o), 512'(0));
        chk("drain_hold_addr", 512'({mem_cmd_v_o, mem_cmd_addr_o}), 512'({1'b1, 40'h0}));
        next_cycle();
        set_cmd(1'b1, 1'b0, 40'h0, 32'h0);
        @(negedge clk_i);
        chk("drain_entry_read_ready", 512'(cmd_ready_o), 512'(1));
        next_cycle();
        set_cmd(1'b0, 1'b0, 40'h0, 32'h0);
        @(negedge clk_i);
        chk("drain_entry_read_resp", 512'({resp_v_o, resp_wr_o}), 512'(2'b10));
        chk("drain_entry_read_data", resp_data_o, 512'(32'h11));
        chk("drain_hold_data", mem_cmd_data_o, 512'(32'h11));
        next_cycle();
        mem_cmd_ready_i = 1'b1;
        @(negedge clk_i);
        chk("drain_handshake_v", 512'(mem_cmd_v_o), 512'(1));
        next_cycle();
        mem_cmd_ready_i = 1'b0;
        @(negedge clk_i);
        chk("after_drain_occ", 512'(dut.occupancy_r), 512'(2));
        chk("after_drain_idle", 512'(mem_cmd_v_o), 512'(0));
        wait_mem_v(20, "idle_drain_start");
        chk("idle_drain_addr", 512'(mem_cmd_addr_o), 512'(40'h40));
        chk("idle_drain_data", mem_cmd_data_o, 512'(32'h22));

        // Full buffer stall on write miss until a drain frees an entry
        do_reset("reset2");
        resp_yumi_i = 1'b1;
        set_cmd(1'b1, 1'b1, 40'h0, 32'h1);
        next_cycle();
        set_cmd(1'b1, 1'b1, 40'h40, 32'h2);
        next_cycle();
        set_cmd(1'b1, 1'b1, 40'h80, 32'h3);
        next_cycle();
        set_cmd(1'b1, 1'b1, 40'hC0, 32'h4);
        @(negedge clk_i);
        chk("fill_fourth_ready", 512'(cmd_ready_o), 512'(1));
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            set_cmd(1'b1, 1'b1, 40'h100, 32'h5);
            @(negedge clk_i);
            chk($sformatf("full_stall%0d_ready", k), 512'(cmd_ready_o), 512'(0));
            chk($sformatf("full_stall%0d_occ", k), 512'(dut.occupancy_r), 512'(4));
        end
        next_cycle();
        mem_cmd_ready_i = 1'b1;
        @(negedge clk_i);
        chk("full_handshake_ready", 512'(cmd_ready_o), 512'(0));
        chk("full_handshake_addr", 512'(mem_cmd_addr_o), 512'(40'h0));
        next_cycle();
        mem_cmd_ready_i = 1'b0;
        @(negedge clk_i);
        chk("full_release_ready", 512'(cmd_ready_o), 512'(1));
        chk("full_release_occ", 512'(dut.occupancy_r), 512'(3));
        next_cycle();
        set_cmd(1'b0, 1'b0, 40'h0, 32'h0);
        @(negedge clk_i);
        chk("refill_occ", 512'(dut.occupancy_r), 512'(4));
        chk("redrain_addr", 512'({mem_cmd_v_o, mem_cmd_addr_o}), 512'({1'b1, 40'h40}));

        // Asynchronous reset in the middle of a drain with busy inputs
        set_cmd(1'b1, 1'b0, 40'h2000, 32'h0);
        mem_resp_v_i    = 1'b1;
        mem_resp_wr_i   = 1'b0;
        mem_resp_data_i = 512'(32'h77);
        #2;
        reset_n_i = 1'b0;
        #1;
        chk_all_zero("mid_drain_reset");
        repeat (2) @(posedge clk_i);
        #1;
        chk_all_zero("mid_drain_reset_held");
        set_cmd(1'b0, 1'b0, 40'h0, 32'h0);
        mem_resp_v_i = 1'b0;
        reset_n_i    = 1'b1;
        repeat (2) @(posedge clk_i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
